// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: combinational hit path, 16-byte
// block fill from instruction memory through a read/busywait handshake.
module icache #(
    parameter int INDEX_BITS = 3,
    parameter int TAG_BITS   = 10 - 4 - INDEX_BITS
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic [31:0]                  PC,
    output logic [31:0]                  INSTRUCTION,
    output logic                         BUSYWAIT,
    output logic                         MEM_READ,
    output logic [TAG_BITS+INDEX_BITS-1:0] MEM_ADDRESS,
    input  logic [127:0]                 MEM_READDATA,
    input  logic                         MEM_BUSYWAIT
);
    localparam int LINES   = 1 << INDEX_BITS;
    localparam int BA_BITS = TAG_BITS + INDEX_BITS;

    typedef enum logic [1:0] {S_IDLE, S_MEM_READ, S_UPDATE} state_t;

    state_t               state_q, state_d;
    logic [BA_BITS-1:0]   miss_addr_q, miss_addr_d;
    logic [LINES-1:0]     valid_q, valid_d;
    logic                 mem_read_q, mem_read_d;
    logic [127:0]         block_q, block_d;
    logic [TAG_BITS-1:0]  tag_q [LINES];
    logic [127:0]         data_q [LINES];
    logic                 fill_en;

    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]   tag;
    logic [1:0]            offset;
    logic [INDEX_BITS-1:0] fill_idx;
    logic                  hit;
    logic                  unused_pc;

    assign index     = PC[4 +: INDEX_BITS];
    assign tag       = PC[9 -: TAG_BITS];
    assign offset    = PC[3:2];
    assign fill_idx  = miss_addr_q[INDEX_BITS-1:0];
    assign unused_pc = ^{PC[31:10], PC[1:0]};

    assign hit = (state_q == S_IDLE) && valid_q[index] && (tag_q[index] == tag);

    // Outputs are forced quiet while reset is held, even though the state is already idle.
    always_comb begin
        INSTRUCTION = 32'h0;
        BUSYWAIT    = 1'b0;
        if (!RESET) begin
            BUSYWAIT = !hit;
            if (hit) INSTRUCTION = data_q[index][{offset, 5'b0} +: 32];
        end
    end

    assign MEM_READ    = mem_read_q;
    assign MEM_ADDRESS = mem_read_q ? miss_addr_q : '0;

    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        valid_d     = valid_q;
        block_d     = block_q;
        fill_en     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!hit) begin
                    miss_addr_d = PC[4 +: BA_BITS];
                    state_d     = S_MEM_READ;
                end
            end
            S_MEM_READ: begin
                if (!MEM_BUSYWAIT) begin
                    block_d = MEM_READDATA;
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                fill_en           = 1'b1;
                valid_d[fill_idx] = 1'b1;
                state_d           = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        mem_read_d = (state_d == S_MEM_READ);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            miss_addr_q <= '0;
            valid_q     <= '0;
            mem_read_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            valid_q     <= valid_d;
            mem_read_q  <= mem_read_d;
        end
    end

    // Line payload needs no reset: the valid bits alone gate every hit.
    always_ff @(posedge CLK) begin
        block_q <= block_d;
        if (fill_en) begin
            data_q[fill_idx] <= block_q;
            tag_q[fill_idx]  <= miss_addr_q[BA_BITS-1 -: TAG_BITS];
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache with a 4-cycle-latency instruction memory model.
module tb_icache;
    logic         CLK = 1'b0;
    logic         RESET;
    logic [31:0]  PC;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic         MEM_READ;
    logic [5:0]   MEM_ADDRESS;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;

    int n_chk = 0;
    int n_err = 0;
    int mem_cnt = 0;

    icache dut (
        .CLK(CLK), .RESET(RESET), .PC(PC), .INSTRUCTION(INSTRUCTION),
        .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ), .MEM_ADDRESS(MEM_ADDRESS),
        .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    // Block 0 holds the given pattern; other blocks hold 0x1000_0000 | addr<<8 | word.
    function automatic logic [127:0] blk(input logic [5:0] a);
        logic [127:0] r;
        if (a == 6'h00) r = {32'h44332211, 32'h0A0B0C0D, 32'h01020304, 32'hDEADBEEF};
        else for (int k = 0; k < 4; k++) r[32*k +: 32] = 32'h1000_0000 | (32'(a) << 8) | 32'(k);
        return r;
    endfunction

    always @(posedge CLK) mem_cnt <= MEM_READ ? mem_cnt + 1 : 0;
    always_comb begin
        MEM_READDATA = blk(MEM_ADDRESS);
        MEM_BUSYWAIT = MEM_READ && (mem_cnt < 3);
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    // Entered in an IDLE miss cycle; leaves in the first IDLE cycle after the fill.
    task automatic fill(input logic [5:0] addr, input logic [31:0] pc_after,
                        input logic [31:0] exp_instr, input string tag);
        int reads = 0;
        chk({tag, "_miss_bw"}, BUSYWAIT, 1);
        chk({tag, "_miss_instr"}, INSTRUCTION, 0);
        chk({tag, "_miss_mr"}, MEM_READ, 0);
        step();
        PC = pc_after;
        #1;
        while (MEM_READ && reads < 50) begin
            chk({tag, "_rd_addr"}, MEM_ADDRESS, addr);
            chk({tag, "_rd_bw"}, BUSYWAIT, 1);
            reads++;
            step();
            #1;
        end
        chk({tag, "_rd_cycles"}, reads, 4);
        chk({tag, "_upd_bw"}, BUSYWAIT, 1);
        chk({tag, "_upd_addr"}, MEM_ADDRESS, 0);
        step();
        #1;
        chk({tag, "_done_bw"}, BUSYWAIT, 0);
        chk({tag, "_done_instr"}, INSTRUCTION, exp_instr);
    endtask

    task automatic hit(input logic [31:0] pc, input logic [31:0] exp_instr, input string tag);
        step();
        PC = pc;
        #1;
        chk({tag, "_bw"}, BUSYWAIT, 0);
        chk({tag, "_mr"}, MEM_READ, 0);
        chk({tag, "_instr"}, INSTRUCTION, exp_instr);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        RESET = 1'b1;
        PC    = 32'h0;
        #12;
        chk("rst_bw", BUSYWAIT, 0);
        chk("rst_instr", INSTRUCTION, 0);
        chk("rst_mr", MEM_READ, 0);
        chk("rst_addr", MEM_ADDRESS, 0);

        // Cold start and sequential hits within block 0
        step();
        RESET = 1'b0;
        #1;
        fill(6'h00, 32'h0, 32'hDEADBEEF, "cold");
        hit(32'h4, 32'h01020304, "seq4");
        hit(32'h8, 32'h0A0B0C0D, "seq8");
        hit(32'hC, 32'h44332211, "seq12");

        // Conflict on index 0, then back to block 0
        step(); PC = 32'h080; #1;
        fill(6'h08, 32'h080, 32'h10000800, "conf80");
        step(); PC = 32'h0; #1;
        fill(6'h00, 32'h0, 32'hDEADBEEF, "conf0");

        // Distinct indices, then hits including upper PC bits set
        step(); PC = 32'h010; #1;
        fill(6'h01, 32'h010, 32'h10000100, "idx1");
        step(); PC = 32'h3F0; #1;
        fill(6'h3F, 32'h3F0, 32'h10003F00, "idx7");
        hit(32'h010, 32'h10000100, "hit010");
        hit(32'h3F0, 32'h10003F00, "hit3F0");
        hit(32'hFFFFFC10, 32'h10000100, "hitHigh");
        hit(32'h0, 32'hDEADBEEF, "hit0");

        // Reset during the second MEM_READ cycle
        step(); PC = 32'h100; #1;
        chk("mid_miss_bw", BUSYWAIT, 1);
        step(); #1;
        chk("mid_rd1", MEM_READ, 1);
        step(); #1;
        chk("mid_rd2", MEM_READ, 1);
        RESET = 1'b1;
        #1;
        chk("mid_rst_mr", MEM_READ, 0);
        chk("mid_rst_bw", BUSYWAIT, 0);
        chk("mid_rst_instr", INSTRUCTION, 0);
        chk("mid_rst_addr", MEM_ADDRESS, 0);
        step();
        step();
        RESET = 1'b0;
        PC = 32'h0;
        #1;
        fill(6'h00, 32'h0, 32'hDEADBEEF, "refill");

        // PC moves within the block while the fill is in flight
        step(); PC = 32'h020; #1;
        fill(6'h02, 32'h024, 32'h10000201, "pcchg");
        step(); #1;
        chk("pcchg_after_mr", MEM_READ, 0);
        chk("pcchg_after_bw", BUSYWAIT, 0);
        chk("pcchg_after_instr", INSTRUCTION, 32'h10000201);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
